// File: rtl/uart_reg_bridge_pkg.sv
// Shared constants and state encoding for the UART register bridge.
// Imported by the bridge FSM and anything that decodes its state.
package uart_reg_bridge_pkg;

  typedef enum logic [2:0] {
    BR_IDLE      = 3'd0,
    BR_WAIT_DATA = 3'd1,
    BR_WRITE     = 3'd2,
    BR_READ_REQ  = 3'd3,
    BR_READ_WAIT = 3'd4,
    BR_TX_SEND   = 3'd5,
    BR_TX_BUSY   = 3'd6
  } br_state_t;

  localparam int CMD_WRITE_BIT    = 7;
  localparam int C_BRIDGE_TIMEOUT = 2500000;

endpackage

// File: rtl/uart_reg_bridge.sv
// UART command bridge: turns received bytes into register
// writes/reads and sends read data back over UART TX.
module uart_reg_bridge
  import uart_reg_bridge_pkg::*;
#(
  parameter int ADDR_WIDTH   = 5,
  parameter int DATA_WIDTH   = 8,
  parameter int READ_LATENCY = 1,
  parameter int C_TIMEOUT    = C_BRIDGE_TIMEOUT
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst_N,
  input  logic                  i_Rx_DV,
  input  logic [7:0]            i_Rx_Byte,
  input  logic                  i_Tx_Active,
  output logic                  o_Tx_DV,
  output logic [7:0]            o_Tx_Byte,
  output logic                  o_write_en,
  output logic [ADDR_WIDTH-1:0] o_write_addr,
  output logic [DATA_WIDTH-1:0] o_write_data,
  output logic                  o_read_en,
  output logic [ADDR_WIDTH-1:0] o_read_addr,
  input  logic [DATA_WIDTH-1:0] i_read_data,
  output logic                  o_Busy,
  output logic                  o_Error
);

  localparam int TW =
    (C_TIMEOUT > 2) ? $clog2(C_TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST =
    TW'(C_TIMEOUT - 1);
  localparam logic [1:0] LAT_LAST =
    2'(READ_LATENCY - 1);

  br_state_t       state;
  logic [TW-1:0]   tmo_cnt;
  logic [1:0]      lat_cnt;
  logic            tx_seen;
  logic            cmd_bad;
  logic            cmd_wr;

  assign cmd_bad = (i_Rx_Byte[6:5] != 2'b00);
  assign cmd_wr  = i_Rx_Byte[CMD_WRITE_BIT];
  assign o_Busy  = (state != BR_IDLE);

  // Command FSM with timeout, read-latency and TX handshake tracking
  always_ff @(posedge i_Clk or negedge i_Rst_N) begin
    if (!i_Rst_N) begin
      state        <= BR_IDLE;
      tmo_cnt      <= '0;
      lat_cnt      <= '0;
      tx_seen      <= 1'b0;
      o_Tx_DV      <= 1'b0;
      o_Tx_Byte    <= '0;
      o_write_en   <= 1'b0;
      o_write_addr <= '0;
      o_write_data <= '0;
      o_read_en    <= 1'b0;
      o_read_addr  <= '0;
      o_Error      <= 1'b0;
    end else begin
      o_write_en <= 1'b0;
      o_read_en  <= 1'b0;
      o_Tx_DV    <= 1'b0;
      o_Error    <= 1'b0;
      case (state)
        BR_IDLE: begin
          if (i_Rx_DV) begin
            if (cmd_bad) begin
              o_Error <= 1'b1;
            end else if (cmd_wr) begin
              o_write_addr <= i_Rx_Byte[ADDR_WIDTH-1:0];
              tmo_cnt      <= '0;
              state        <= BR_WAIT_DATA;
            end else begin
              o_read_addr <= i_Rx_Byte[ADDR_WIDTH-1:0];
              o_read_en   <= 1'b1;
              state       <= BR_READ_REQ;
            end
          end
        end
        BR_WAIT_DATA: begin
          if (i_Rx_DV) begin
            o_write_data <= i_Rx_Byte[DATA_WIDTH-1:0];
            o_write_en   <= 1'b1;
            state        <= BR_WRITE;
          end else if (tmo_cnt == TMO_LAST) begin
            o_Error <= 1'b1;
            state   <= BR_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        BR_WRITE: begin
          o_Error <= i_Rx_DV;
          state   <= BR_IDLE;
        end
        BR_READ_REQ: begin
          o_Error <= i_Rx_DV;
          lat_cnt <= '0;
          state   <= BR_READ_WAIT;
        end
        BR_READ_WAIT: begin
          o_Error <= i_Rx_DV;
          if (lat_cnt == LAT_LAST) begin
            o_Tx_Byte <= i_read_data;
            state     <= BR_TX_SEND;
          end else begin
            lat_cnt <= lat_cnt + 1'b1;
          end
        end
        BR_TX_SEND: begin
          o_Error <= i_Rx_DV;
          if (!i_Tx_Active) begin
            o_Tx_DV <= 1'b1;
            tx_seen <= 1'b0;
            lat_cnt <= '0;
            state   <= BR_TX_BUSY;
          end
        end
        BR_TX_BUSY: begin
          o_Error <= i_Rx_DV;
          if (i_Tx_Active) begin
            tx_seen <= 1'b1;
          end else if (tx_seen || lat_cnt == 2'd1) begin
            state <= BR_IDLE;
          end else begin
            lat_cnt <= lat_cnt + 1'b1;
          end
        end
        default: state <= BR_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_reg_bridge.sv
// Directed bench for uart_reg_bridge: table of
// command vectors plus timing corner sequences.
module tb_uart_reg_bridge;

  localparam int AW = 5;
  localparam int DW = 8;

  logic          i_Clk = 1'b0;
  logic          i_Rst_N = 1'b0;
  logic          i_Rx_DV = 1'b0;
  logic [7:0]    i_Rx_Byte = 8'h00;
  logic          i_Tx_Active;
  logic          o_Tx_DV;
  logic [7:0]    o_Tx_Byte;
  logic          o_write_en;
  logic [AW-1:0] o_write_addr;
  logic [DW-1:0] o_write_data;
  logic          o_read_en;
  logic [AW-1:0] o_read_addr;
  logic [DW-1:0] i_read_data = '0;
  logic          o_Busy;
  logic          o_Error;

  uart_reg_bridge #(
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW),
    .READ_LATENCY(1),
    .C_TIMEOUT   (16)
  ) dut (
    .i_Clk       (i_Clk),
    .i_Rst_N     (i_Rst_N),
    .i_Rx_DV     (i_Rx_DV),
    .i_Rx_Byte   (i_Rx_Byte),
    .i_Tx_Active (i_Tx_Active),
    .o_Tx_DV     (o_Tx_DV),
    .o_Tx_Byte   (o_Tx_Byte),
    .o_write_en  (o_write_en),
    .o_write_addr(o_write_addr),
    .o_write_data(o_write_data),
    .o_read_en   (o_read_en),
    .o_read_addr (o_read_addr),
    .i_read_data (i_read_data),
    .o_Busy      (o_Busy),
    .o_Error     (o_Error)
  );

  always #20 i_Clk = ~i_Clk;

  // register file model, one cycle read latency
  logic [7:0] mem [32];
  always @(posedge i_Clk)
    if (o_read_en) i_read_data <= mem[o_read_addr];

  // UART TX model: busy for 5 cycles after a send strobe
  logic       tx_hold = 1'b0;
  logic [3:0] tx_cnt = 4'd0;
  always @(posedge i_Clk)
    if (o_Tx_DV) tx_cnt <= 4'd5;
    else if (tx_cnt != 0) tx_cnt <= tx_cnt - 4'd1;
  assign i_Tx_Active = tx_hold | (tx_cnt != 0);

  // output monitor, cumulative counters
  int n_wr = 0, n_rd = 0, n_tx = 0;
  int n_err = 0, n_busy = 0, n_viol = 0;
  logic [7:0] m_waddr = 0, m_wdata = 0;
  logic [7:0] m_raddr = 0, m_tx = 0;
  logic prev_we = 0, prev_re = 0;
  always @(negedge i_Clk) begin
    if (o_write_en) begin
      n_wr++;
      m_waddr = 8'(o_write_addr);
      m_wdata = o_write_data;
    end
    if (o_read_en) begin
      n_rd++;
      m_raddr = 8'(o_read_addr);
    end
    if (o_Tx_DV) begin
      n_tx++;
      m_tx = o_Tx_Byte;
    end
    if (o_Error) n_err++;
    if (o_Busy) n_busy++;
    if (o_write_en && o_read_en) n_viol++;
    if (o_write_en && prev_we) n_viol++;
    if (o_read_en && prev_re) n_viol++;
    prev_we = o_write_en;
    prev_re = o_read_en;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  // call at a negedge; byte is sampled at the next posedge
  task automatic send_byte(input logic [7:0] b);
    i_Rx_DV   = 1'b1;
    i_Rx_Byte = b;
    @(negedge i_Clk);
    i_Rx_DV   = 1'b0;
  endtask

  typedef struct {
    logic [7:0] cmd;
    logic [7:0] dat;
    bit         snd;
    int         wr;
    int         rd;
    int         tx;
    int         err;
    logic [7:0] addr;
    logic [7:0] val;
  } vec_t;

  vec_t vecs [9];

  int s_wr, s_rd, s_tx, s_err, s_busy;

  task automatic snap();
    s_wr = n_wr; s_rd = n_rd; s_tx = n_tx;
    s_err = n_err; s_busy = n_busy;
  endtask

  initial begin
    int first;
    for (int i = 0; i < 32; i++) mem[i] = 8'h00;
    mem[0]  = 8'h3C;
    mem[7]  = 8'hC3;
    mem[17] = 8'h5E;
    mem[31] = 8'hA5;

    vecs[0] = '{8'h83, 8'h5A, 1, 1, 0, 0, 0, 8'd3,  8'h5A};
    vecs[1] = '{8'h07, 8'h00, 0, 0, 1, 1, 0, 8'd7,  8'hC3};
    vecs[2] = '{8'hA1, 8'h00, 0, 0, 0, 0, 1, 8'd0,  8'h00};
    vecs[3] = '{8'h9F, 8'hFF, 1, 1, 0, 0, 0, 8'd31, 8'hFF};
    vecs[4] = '{8'h00, 8'h00, 0, 0, 1, 1, 0, 8'd0,  8'h3C};
    vecs[5] = '{8'h1F, 8'h00, 0, 0, 1, 1, 0, 8'd31, 8'hA5};
    vecs[6] = '{8'h40, 8'h00, 0, 0, 0, 0, 1, 8'd0,  8'h00};
    vecs[7] = '{8'h80, 8'h00, 1, 1, 0, 0, 0, 8'd0,  8'h00};
    vecs[8] = '{8'hE0, 8'h00, 0, 0, 0, 0, 1, 8'd0,  8'h00};

    // reset state
    repeat (3) @(negedge i_Clk);
    check("rst_outs",
      {o_Tx_DV, o_Tx_Byte, o_write_en, 3'b0, o_write_addr,
       o_write_data, o_read_en, o_read_addr, o_Busy, o_Error},
      32'h0);
    i_Rst_N = 1'b1;
    repeat (2) @(negedge i_Clk);
    check("idle_busy", {31'b0, o_Busy}, 32'h0);

    // table vectors
    for (int v = 0; v < 9; v++) begin
      snap();
      send_byte(vecs[v].cmd);
      if (vecs[v].snd) begin
        repeat (2) @(negedge i_Clk);
        send_byte(vecs[v].dat);
      end
      repeat (20) @(negedge i_Clk);
      check($sformatf("v%0d_wr", v), n_wr - s_wr, vecs[v].wr);
      check($sformatf("v%0d_rd", v), n_rd - s_rd, vecs[v].rd);
      check($sformatf("v%0d_tx", v), n_tx - s_tx, vecs[v].tx);
      check($sformatf("v%0d_err", v), n_err - s_err, vecs[v].err);
      check($sformatf("v%0d_busy", v),
            {31'b0, (n_busy - s_busy) != 0},
            {31'b0, (vecs[v].wr + vecs[v].rd) != 0});
      if (vecs[v].wr != 0) begin
        check($sformatf("v%0d_waddr", v), m_waddr, vecs[v].addr);
        check($sformatf("v%0d_wdata", v), m_wdata, vecs[v].val);
      end
      if (vecs[v].rd != 0) begin
        check($sformatf("v%0d_raddr", v), m_raddr, vecs[v].addr);
        check($sformatf("v%0d_txb", v), m_tx, vecs[v].val);
      end
    end

    // timeout: error exactly 16 cycles after the command edge
    snap();
    send_byte(8'h82);
    first = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge i_Clk);
      if (k == 1) check("tmo_busy", {31'b0, o_Busy}, 32'h1);
      if (o_Error && first == 0) first = k;
    end
    check("tmo_cycle", first, 16);
    check("tmo_err", n_err - s_err, 1);
    check("tmo_nowr", n_wr - s_wr, 0);
    check("tmo_idle", {31'b0, o_Busy}, 32'h0);

    // data byte on the timeout cycle wins
    snap();
    send_byte(8'h84);
    repeat (15) @(negedge i_Clk);
    send_byte(8'h6B);
    repeat (5) @(negedge i_Clk);
    check("edge_wr", n_wr - s_wr, 1);
    check("edge_err", n_err - s_err, 0);
    check("edge_waddr", m_waddr, 8'd4);
    check("edge_wdata", m_wdata, 8'h6B);

    // TX backpressure with an overrun byte
    snap();
    tx_hold = 1'b1;
    send_byte(8'h07);
    repeat (10) @(negedge i_Clk);
    send_byte(8'h55);
    repeat (40) @(negedge i_Clk);
    check("bp_rd", n_rd - s_rd, 1);
    check("bp_notx", n_tx - s_tx, 0);
    check("bp_err", n_err - s_err, 1);
    check("bp_busy", {31'b0, o_Busy}, 32'h1);
    tx_hold = 1'b0;
    repeat (20) @(negedge i_Clk);
    check("bp_tx", n_tx - s_tx, 1);
    check("bp_txb", m_tx, 8'hC3);
    check("bp_idle", {31'b0, o_Busy}, 32'h0);

    // reset in WAIT_DATA, then a read command
    snap();
    send_byte(8'h81);
    repeat (2) @(negedge i_Clk);
    i_Rst_N = 1'b0;
    #1;
    check("arst_busy", {31'b0, o_Busy}, 32'h0);
    repeat (2) @(negedge i_Clk);
    i_Rst_N = 1'b1;
    repeat (3) @(negedge i_Clk);
    check("rst_nowr", n_wr - s_wr, 0);
    send_byte(8'h11);
    repeat (20) @(negedge i_Clk);
    check("rst_wr", n_wr - s_wr, 0);
    check("rst_rd", n_rd - s_rd, 1);
    check("rst_raddr", m_raddr, 8'd17);
    check("rst_txb", m_tx, 8'h5E);
    check("rst_err", n_err - s_err, 0);

    check("strobe_rules", n_viol, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
